// File: rtl/branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predict_ctrl
//  Description : Branch sequencing controller for a 5-stage pipeline.
//                - Predicts branch direction at IF from a table of 2-bit
//                  saturating counters (BHT) indexed by pc[IDX_W+1:2].
//                - Resolves branches/JALR at EX, trains the BHT, and on a
//                  mispredict redirects the PC and squashes the younger
//                  stages for FLUSH_CYCLES consecutive cycles.
//                - Keeps saturating resolved-branch and mispredict counters.
//  Ports       :
//    clk, rst             clock, asynchronous active-high reset
//    if_pc/if_is_branch/if_target   IF-stage instruction info
//    pred_taken, pred_pc            prediction and next fetch PC
//    ex_branch/ex_jalr/ex_pc/ex_taken/ex_pred_taken/ex_target
//                                   EX-stage resolution inputs
//    stall                          pipeline hold, EX inputs ignored
//    flush                          squash IF/ID and ID/EX
//    redirect_valid, redirect_pc    PC correction
//    br_count, mp_count             debug performance counters
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_ctrl #(
    parameter int IDX_W        = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_pc,
    input  logic             if_is_branch,
    input  logic [31:0]      if_target,
    output logic             pred_taken,
    output logic [31:0]      pred_pc,
    input  logic             ex_branch,
    input  logic             ex_jalr,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_target,
    input  logic             stall,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);

    localparam int         c_ENTRIES    = 2 ** IDX_W;
    // Cycles remaining in FLUSH after the mispredict cycle itself.
    localparam logic [2:0] c_FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_cnt;
    logic [2:0]       w_cnt_nxt;
    logic [1:0]       r_bht [c_ENTRIES];
    logic [1:0]       w_bht_nxt;
    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic             w_ev;
    logic             w_mp;
    logic             w_upd;

    // ------------------------------------------------------------------
    // Prediction (reads the registered table, so a same-cycle update of
    // the same entry is not visible until the next cycle)
    // ------------------------------------------------------------------
    assign w_if_idx   = if_pc[IDX_W+1:2];
    assign pred_taken = if_is_branch & r_bht[w_if_idx][1];
    assign pred_pc    = pred_taken ? if_target : (if_pc + 32'd4);

    // ------------------------------------------------------------------
    // Resolution. Only accepted in IDLE: during FLUSH the EX instruction
    // is a squashed wrong-path one.
    // ------------------------------------------------------------------
    assign w_ex_idx = ex_pc[IDX_W+1:2];
    assign w_ev     = (ex_branch | ex_jalr) & ~stall & (r_state == ST_IDLE);
    // JALR is never predicted, so it always counts as a mispredict.
    assign w_mp     = w_ev & (ex_jalr | (ex_branch & (ex_taken != ex_pred_taken)));
    // JALR wins when both flags are set; the BHT is trained only by branches.
    assign w_upd    = w_ev & ex_branch & ~ex_jalr;

    // Outputs are gated by rst because w_mp is combinational from inputs
    // and would otherwise leak through while reset is held.
    assign redirect_valid = w_mp & ~rst;
    assign redirect_pc    = (ex_jalr | ex_taken) ? ex_target : (ex_pc + 32'd4);
    assign flush          = ~rst & ((r_state == ST_FLUSH) | w_mp);

    // ------------------------------------------------------------------
    // Squash FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                // With a single flush cycle the mispredict cycle alone
                // covers it and FLUSH is never entered.
                if (w_mp && (FLUSH_CYCLES > 1)) begin
                    w_state_nxt = ST_FLUSH;
                    w_cnt_nxt   = c_FLUSH_INIT;
                end
            end
            ST_FLUSH: begin
                // stall deliberately does not hold the count.
                if (r_cnt <= 3'd1) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 3'd0;
                end else begin
                    w_cnt_nxt   = r_cnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // BHT training: 2-bit saturating counter, 00..11
    // ------------------------------------------------------------------
    always_comb begin
        w_bht_nxt = r_bht[w_ex_idx];
        if (ex_taken) begin
            if (r_bht[w_ex_idx] != 2'b11) w_bht_nxt = r_bht[w_ex_idx] + 2'b01;
        end else begin
            if (r_bht[w_ex_idx] != 2'b00) w_bht_nxt = r_bht[w_ex_idx] - 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_upd) begin
            r_bht[w_ex_idx] <= w_bht_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Debug counters, saturating at all-ones
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count <= '0;
            mp_count <= '0;
        end else begin
            if (w_upd && (br_count != '1)) br_count <= br_count + 1'b1;
            if (w_mp  && (mp_count != '1)) mp_count <= mp_count + 1'b1;
        end
    end

endmodule
`default_nettype wire
